ppl_memaccess: RTL and testbench

- Consumer end of the execute stage. Registers the EX results (ALU value, store data, destination register, control) into the EX/MEM pipeline register.
- Performs data-memory access over a req/ack handshake and stalls the pipeline while a request is outstanding.
- Produces a registered MEM/WB result: destination register, write enable, and aligned/extended write-back data.
- Exposes EX/MEM fields to the forwarding/hazard logic.

---
 rtl/ppl_pkg.sv | 29 ++
 rtl/ppl_load_align.sv | 39 +++
 rtl/ppl_memaccess.sv | 162 ++++++++++++++++
 tb/tb_ppl_memaccess.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ppl_pkg
// Description : Shared access-size encodings and byte-enable constants for the
//               memory-access stage.
// Revision    : 1.0 - initial release
// ============================================================================
package ppl_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    // Reserved size 2'b11 is handled as a word everywhere.
    function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_HALF: f_misaligned = lo[0];
            SZ_BYTE: f_misaligned = 1'b0;
            default: f_misaligned = (lo != 2'b00);
        endcase
    endfunction

endpackage : ppl_pkg
`default_nettype wire

// File: rtl/ppl_load_align.sv
`default_nettype none
// ============================================================================
// Module      : ppl_load_align
// Description : Load lane select with sign/zero extension (little-endian).
// Revision    : 1.0 - initial release
// ============================================================================
import ppl_pkg::*;

module ppl_load_align (
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        o_data = i_rdata;
        case (i_size)
            SZ_HALF: o_data = i_signed ? {{16{w_half[15]}}, w_half} : {16'h0000, w_half};
            SZ_BYTE: o_data = i_signed ? {{24{w_byte[7]}}, w_byte} : {24'h000000, w_byte};
            default: o_data = i_rdata;
        endcase
    end

endmodule : ppl_load_align
`default_nettype wire

// File: rtl/ppl_memaccess.sv
`default_nettype none
// ============================================================================
// Module      : ppl_memaccess
// Description : EX/MEM register, data-memory req/ack access and MEM/WB result.
//               MEM_ALIGN_EXC_EN adds memAlignExc and squashes misaligned ops.
// Revision    : 1.0 - initial release
// ============================================================================
import ppl_pkg::*;

module ppl_memaccess #(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              exWreg,
    input  logic              exM2reg,
    input  logic              exWmem,
    input  logic [1:0]        exSize,
    input  logic              exSigned,
    input  logic [31:0]       exAlu,
    input  logic [31:0]       exDataB,
    input  logic [4:0]        exReg,
    output logic              dmemReq,
    output logic              dmemWe,
    output logic [ADDR_W-1:0] dmemAddr,
    output logic [3:0]        dmemBe,
    output logic [31:0]       dmemWdata,
    input  logic              dmemAck,
    input  logic [31:0]       dmemRdata,
    output logic              memStall,
    output logic              mWreg,
    output logic              mM2reg,
    output logic [4:0]        mReg,
    output logic [31:0]       mAlu,
    output logic              wbWreg,
    output logic [4:0]        wbReg,
    output logic [31:0]       wbData
`ifdef MEM_ALIGN_EXC_EN
    ,
    output logic              memAlignExc
`endif
);

    logic        r_wreg, r_m2reg, r_wmem, r_signed;
    logic [1:0]  r_size;
    logic [31:0] r_alu, r_datab;
    logic [4:0]  r_reg;
    logic        r_wb_wreg;
    logic [4:0]  r_wb_reg;
    logic [31:0] r_wb_data;

    logic        w_memop, w_misalign, w_req;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_load;

    assign w_memop = r_m2reg | r_wmem;
`ifdef MEM_ALIGN_EXC_EN
    assign w_misalign = w_memop & f_misaligned(r_size, r_alu[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_req     = w_memop & ~w_misalign;
    assign dmemReq   = w_req;
    assign memStall  = w_req & ~dmemAck;
    assign dmemWe    = w_req & r_wmem;
    assign dmemAddr  = {r_alu[ADDR_W-1:2], 2'b00};
    assign dmemBe    = w_req ? w_be : 4'b0000;
    assign dmemWdata = w_wdata;

    always_comb begin
        w_be    = BE_WORD;
        w_wdata = r_datab;
        case (r_size)
            SZ_BYTE: begin
                w_be    = BE_BYTE0 << r_alu[1:0];
                w_wdata = {4{r_datab[7:0]}};
            end
            SZ_HALF: begin
                w_be    = r_alu[1] ? BE_HALF_HI : BE_HALF_LO;
                w_wdata = {2{r_datab[15:0]}};
            end
            default: begin
                w_be    = BE_WORD;
                w_wdata = r_datab;
            end
        endcase
        if (r_m2reg) begin
            w_be = BE_WORD;
        end
    end

    ppl_load_align u_load_align (
        .i_rdata   (dmemRdata),
        .i_addr_lo (r_alu[1:0]),
        .i_size    (r_size),
        .i_signed  (r_signed),
        .o_data    (w_load)
    );

    // EX/MEM freezes while an access is outstanding.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_wreg   <= 1'b0;
            r_m2reg  <= 1'b0;
            r_wmem   <= 1'b0;
            r_signed <= 1'b0;
            r_size   <= 2'b00;
            r_alu    <= 32'h0;
            r_datab  <= 32'h0;
            r_reg    <= 5'd0;
        end else if (!memStall) begin
            r_wreg   <= exWreg;
            r_m2reg  <= exM2reg;
            r_wmem   <= exWmem;
            r_signed <= exSigned;
            r_size   <= exSize;
            r_alu    <= exAlu;
            r_datab  <= exDataB;
            r_reg    <= exReg;
        end
    end

    // MEM/WB takes a bubble during a stall; reg/data keep their last value.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_wb_wreg <= 1'b0;
            r_wb_reg  <= 5'd0;
            r_wb_data <= 32'h0;
        end else if (memStall) begin
            r_wb_wreg <= 1'b0;
        end else begin
            r_wb_wreg <= r_wreg & ~w_misalign;
            r_wb_reg  <= r_reg;
            r_wb_data <= r_m2reg ? w_load : r_alu;
        end
    end

`ifdef MEM_ALIGN_EXC_EN
    logic r_align_exc;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_align_exc <= 1'b0;
        end else begin
            r_align_exc <= w_misalign;
        end
    end

    assign memAlignExc = r_align_exc;
`endif

    assign mWreg  = r_wreg;
    assign mM2reg = r_m2reg;
    assign mReg   = r_reg;
    assign mAlu   = r_alu;
    assign wbWreg = r_wb_wreg;
    assign wbReg  = r_wb_reg;
    assign wbData = r_wb_data;

endmodule : ppl_memaccess
`default_nettype wire

// File: tb/tb_ppl_memaccess.sv
`default_nettype none
// ============================================================================
// Module      : tb_ppl_memaccess
// Description : Directed self-checking bench for ppl_memaccess.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ppl_memaccess;

    logic        clock = 1'b0;
    logic        resetn;
    logic        exWreg, exM2reg, exWmem, exSigned;
    logic [1:0]  exSize;
    logic [31:0] exAlu, exDataB;
    logic [4:0]  exReg;
    logic        dmemReq, dmemWe, dmemAck, memStall;
    logic [31:0] dmemAddr, dmemWdata, dmemRdata;
    logic [3:0]  dmemBe;
    logic        mWreg, mM2reg, wbWreg;
    logic [4:0]  mReg, wbReg;
    logic [31:0] mAlu, wbData;
`ifdef MEM_ALIGN_EXC_EN
    logic        memAlignExc;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    ppl_memaccess #(.ADDR_W(32)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .exWreg    (exWreg),
        .exM2reg   (exM2reg),
        .exWmem    (exWmem),
        .exSize    (exSize),
        .exSigned  (exSigned),
        .exAlu     (exAlu),
        .exDataB   (exDataB),
        .exReg     (exReg),
        .dmemReq   (dmemReq),
        .dmemWe    (dmemWe),
        .dmemAddr  (dmemAddr),
        .dmemBe    (dmemBe),
        .dmemWdata (dmemWdata),
        .dmemAck   (dmemAck),
        .dmemRdata (dmemRdata),
        .memStall  (memStall),
        .mWreg     (mWreg),
        .mM2reg    (mM2reg),
        .mReg      (mReg),
        .mAlu      (mAlu),
        .wbWreg    (wbWreg),
        .wbReg     (wbReg),
        .wbData    (wbData)
`ifdef MEM_ALIGN_EXC_EN
        ,
        .memAlignExc (memAlignExc)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic wreg, input logic m2reg, input logic wmem,
                         input logic [1:0] size, input logic sgn,
                         input logic [31:0] alu, input logic [31:0] datab, input logic [4:0] rd);
        exWreg   = wreg;
        exM2reg  = m2reg;
        exWmem   = wmem;
        exSize   = size;
        exSigned = sgn;
        exAlu    = alu;
        exDataB  = datab;
        exReg    = rd;
    endtask

    task automatic nop();
        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn    = 1'b0;
        dmemAck   = 1'b0;
        dmemRdata = 32'h0;
        nop();
        tick();
        tick();
        check("rst_wbWreg",   {31'h0, wbWreg},   32'h0);
        check("rst_wbReg",    {27'h0, wbReg},    32'h0);
        check("rst_wbData",   wbData,            32'h0);
        check("rst_mAlu",     mAlu,              32'h0);
        check("rst_mReg",     {27'h0, mReg},     32'h0);
        check("rst_dmemReq",  {31'h0, dmemReq},  32'h0);
        check("rst_memStall", {31'h0, memStall}, 32'h0);
        resetn = 1'b1;

        // Reset while a load waits for its ack
        drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'h0, 5'd3);
        tick();
        nop();
        check("rw_req",   {31'h0, dmemReq},  32'h1);
        check("rw_stall", {31'h0, memStall}, 32'h1);
        check("rw_we",    {31'h0, dmemWe},   32'h0);
        check("rw_be",    {28'h0, dmemBe},   32'hF);
        tick();
        tick();
        check("rw_req_held", {31'h0, dmemReq}, 32'h1);
        check("rw_mReg_held", {27'h0, mReg},   32'h3);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("rw_req_after_rst",   {31'h0, dmemReq},  32'h0);
        check("rw_stall_after_rst", {31'h0, memStall}, 32'h0);
        check("rw_wbWreg_after_rst", {31'h0, wbWreg},  32'h0);
        dmemAck = 1'b1;
        tick();
        dmemAck = 1'b0;
        check("rw_late_ack_wbWreg", {31'h0, wbWreg}, 32'h0);
        check("rw_late_ack_req",    {31'h0, dmemReq}, 32'h0);

        // ALU op
        drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_1234, 32'h0, 5'd8);
        tick();
        nop();
        check("alu_mAlu",  mAlu,            32'h0000_1234);
        check("alu_mWreg", {31'h0, mWreg},  32'h1);
        check("alu_stall", {31'h0, memStall}, 32'h0);
        tick();
        check("alu_wbWreg", {31'h0, wbWreg}, 32'h1);
        check("alu_wbReg",  {27'h0, wbReg},  32'h8);
        check("alu_wbData", wbData,          32'h0000_1234);

        // lb signed at 0x103, two wait cycles
        drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_0103, 32'h0, 5'd5);
        tick();
        nop();
        dmemRdata = 32'h80FF_0000;
        check("lb_mM2reg", {31'h0, mM2reg},   32'h1);
        check("lb_stall1", {31'h0, memStall}, 32'h1);
        check("lb_addr",   dmemAddr,          32'h0000_0100);
        tick();
        check("lb_stall2", {31'h0, memStall}, 32'h1);
        check("lb_bubble", {31'h0, wbWreg},   32'h0);
        tick();
        dmemAck = 1'b1;
        #1;
        check("lb_ack_nostall", {31'h0, memStall}, 32'h0);
        check("lb_ack_req",     {31'h0, dmemReq},  32'h1);
        tick();
        dmemAck = 1'b0;
        check("lb_wbData", wbData,          32'hFFFF_FF80);
        check("lb_wbWreg", {31'h0, wbWreg}, 32'h1);
        check("lb_wbReg",  {27'h0, wbReg},  32'h5);
        check("lb_req_done", {31'h0, dmemReq}, 32'h0);

        // lhu at 0x102, zero wait
        drive(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 5'd6);
        tick();
        nop();
        dmemRdata = 32'hBEEF_1234;
        dmemAck   = 1'b1;
        #1;
        check("lhu_stall", {31'h0, memStall}, 32'h0);
        check("lhu_req",   {31'h0, dmemReq},  32'h1);
        tick();
        dmemAck = 1'b0;
        check("lhu_wbData", wbData,         32'h0000_BEEF);
        check("lhu_wbReg",  {27'h0, wbReg}, 32'h6);

        // lh signed at 0x100 (low lane)
        drive(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0100, 32'h0, 5'd7);
        tick();
        nop();
        dmemRdata = 32'h1234_8001;
        dmemAck   = 1'b1;
        tick();
        dmemAck = 1'b0;
        check("lh_wbData", wbData, 32'hFFFF_8001);

        // lbu at 0x101
        drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 5'd9);
        tick();
        nop();
        dmemRdata = 32'h0000_9C00;
        dmemAck   = 1'b1;
        tick();
        dmemAck = 1'b0;
        check("lbu_wbData", wbData, 32'h0000_009C);

        // sb 0xAB at 0x201
        drive(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0201, 32'h0000_00AB, 5'd0);
        tick();
        nop();
        dmemAck = 1'b1;
        #1;
        check("sb_req",   {31'h0, dmemReq}, 32'h1);
        check("sb_we",    {31'h0, dmemWe},  32'h1);
        check("sb_addr",  dmemAddr,         32'h0000_0200);
        check("sb_be",    {28'h0, dmemBe},  32'h2);
        check("sb_wdata", dmemWdata,        32'hABAB_ABAB);
        tick();
        dmemAck = 1'b0;
        check("sb_wbWreg", {31'h0, wbWreg}, 32'h0);

        // sh 0xCAFE at 0x302 (upper half)
        drive(1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0302, 32'h1111_CAFE, 5'd0);
        tick();
        nop();
        check("sh_be",    {28'h0, dmemBe}, 32'hC);
        check("sh_wdata", dmemWdata,       32'hCAFE_CAFE);
        dmemAck = 1'b1;
        tick();
        dmemAck = 1'b0;

        // sw at misaligned 0x202
        drive(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0202, 32'h1122_3344, 5'd0);
        tick();
        nop();
`ifdef MEM_ALIGN_EXC_EN
        check("swm_req",   {31'h0, dmemReq},  32'h0);
        check("swm_stall", {31'h0, memStall}, 32'h0);
        check("swm_we",    {31'h0, dmemWe},   32'h0);
        tick();
        check("swm_exc",    {31'h0, memAlignExc}, 32'h1);
        check("swm_wbWreg", {31'h0, wbWreg},      32'h0);
        tick();
        check("swm_exc_pulse", {31'h0, memAlignExc}, 32'h0);
`else
        dmemAck = 1'b1;
        #1;
        check("swm_req",   {31'h0, dmemReq}, 32'h1);
        check("swm_we",    {31'h0, dmemWe},  32'h1);
        check("swm_addr",  dmemAddr,         32'h0000_0200);
        check("swm_be",    {28'h0, dmemBe},  32'hF);
        check("swm_wdata", dmemWdata,        32'h1122_3344);
        tick();
        dmemAck = 1'b0;
        check("swm_wbWreg", {31'h0, wbWreg}, 32'h0);
`endif

        // Misaligned lw at 0x105 with write-back requested
        drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0105, 32'h0, 5'd10);
        tick();
        nop();
        dmemRdata = 32'hDEAD_BEEF;
`ifdef MEM_ALIGN_EXC_EN
        check("lwm_req", {31'h0, dmemReq}, 32'h0);
        tick();
        check("lwm_wbWreg", {31'h0, wbWreg},      32'h0);
        check("lwm_exc",    {31'h0, memAlignExc}, 32'h1);
`else
        dmemAck = 1'b1;
        tick();
        dmemAck = 1'b0;
        check("lwm_wbWreg", {31'h0, wbWreg}, 32'h1);
        check("lwm_wbData", wbData,          32'hDEAD_BEEF);
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ppl_memaccess
`default_nettype wire
